// File: rtl/operand_issue_stage_if.sv
// Bundle of decode, register-file, bypass and execute-side signals around the operand issue stage.
// master is the surrounding pipeline; slave is the stage itself.
interface operand_issue_stage_if #(
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_dst;
   logic              in_we;
   logic              in_load;
   logic [CTRL_W-1:0] in_ctrl;
   logic [4:0]        R_a;
   logic [4:0]        R_b;
   logic [31:0]       RF_A;
   logic [31:0]       RF_B;
   logic              mem_we;
   logic              mem_load;
   logic [4:0]        mem_dst;
   logic [31:0]       mem_data;
   logic              wb_we;
   logic [4:0]        wb_dst;
   logic [31:0]       wb_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_A;
   logic [31:0]       out_B;
   logic [4:0]        out_dst;
   logic              out_we;
   logic              out_load;
   logic [CTRL_W-1:0] out_ctrl;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output in_valid, in_rs, in_rt, in_dst, in_we, in_load, in_ctrl,
      output RF_A, RF_B, mem_we, mem_load, mem_dst, mem_data,
      output wb_we, wb_dst, wb_data, flush, out_ready,
      input  in_ready, R_a, R_b, out_valid, out_A, out_B, out_dst,
      input  out_we, out_load, out_ctrl, stall_count
   );

   modport slave (
      input  in_valid, in_rs, in_rt, in_dst, in_we, in_load, in_ctrl,
      input  RF_A, RF_B, mem_we, mem_load, mem_dst, mem_data,
      input  wb_we, wb_dst, wb_data, flush, out_ready,
      output in_ready, R_a, R_b, out_valid, out_A, out_B, out_dst,
      output out_we, out_load, out_ctrl, stall_count
   );
endinterface

// File: rtl/operand_issue_stage.sv
// Decode-to-execute register: reads the register file, bypasses from MEM/WB and
// inserts bubbles on EX-producer or pending-load hazards.
module operand_issue_stage #(
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input logic                 CLK,
   input logic                 Reset,
   operand_issue_stage_if.slave bus
);

   logic              out_valid_q;
   logic [31:0]       out_a_q;
   logic [31:0]       out_b_q;
   logic [4:0]        out_dst_q;
   logic              out_we_q;
   logic              out_load_q;
   logic [CTRL_W-1:0] out_ctrl_q;
   logic [CNT_W-1:0]  stall_q;

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        hazard;
   logic        advance;

   function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf,
                                           input logic m_we, input logic m_load,
                                           input logic [4:0] m_dst, input logic [31:0] m_data,
                                           input logic w_we, input logic [4:0] w_dst,
                                           input logic [31:0] w_data);
      if (r == 5'd0)                           return 32'd0;
      else if (m_we && !m_load && m_dst == r)  return m_data;
      else if (w_we && w_dst == r)             return w_data;
      else                                     return rf;
   endfunction

   // A source stalls while its producer sits in EX or is a load still in MEM.
   function automatic logic src_hazard(input logic [4:0] r, input logic ex_valid,
                                       input logic ex_we, input logic [4:0] ex_dst,
                                       input logic m_we, input logic m_load,
                                       input logic [4:0] m_dst);
      return (r != 5'd0) &&
             ((ex_valid && ex_we && ex_dst == r) || (m_we && m_load && m_dst == r));
   endfunction

   always_comb begin
      op_a = resolve(bus.in_rs, bus.RF_A, bus.mem_we, bus.mem_load, bus.mem_dst,
                     bus.mem_data, bus.wb_we, bus.wb_dst, bus.wb_data);
      op_b = resolve(bus.in_rt, bus.RF_B, bus.mem_we, bus.mem_load, bus.mem_dst,
                     bus.mem_data, bus.wb_we, bus.wb_dst, bus.wb_data);
      hazard = src_hazard(bus.in_rs, out_valid_q, out_we_q, out_dst_q,
                          bus.mem_we, bus.mem_load, bus.mem_dst) ||
               src_hazard(bus.in_rt, out_valid_q, out_we_q, out_dst_q,
                          bus.mem_we, bus.mem_load, bus.mem_dst);
      advance = !out_valid_q || bus.out_ready;
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_dst_q   <= '0;
         out_we_q    <= 1'b0;
         out_load_q  <= 1'b0;
         out_ctrl_q  <= '0;
         stall_q     <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (advance) begin
         if (bus.in_valid && hazard) begin
            out_valid_q <= 1'b0;
            if (!(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         end else if (bus.in_valid) begin
            out_valid_q <= 1'b1;
            out_a_q     <= op_a;
            out_b_q     <= op_b;
            out_dst_q   <= bus.in_dst;
            out_we_q    <= bus.in_we;
            out_load_q  <= bus.in_load;
            out_ctrl_q  <= bus.in_ctrl;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.R_a         = bus.in_rs;
   assign bus.R_b         = bus.in_rt;
   assign bus.in_ready    = bus.flush || (advance && !hazard);
   assign bus.out_valid   = out_valid_q;
   assign bus.out_A       = out_a_q;
   assign bus.out_B       = out_b_q;
   assign bus.out_dst     = out_dst_q;
   assign bus.out_we      = out_we_q;
   assign bus.out_load    = out_load_q;
   assign bus.out_ctrl    = out_ctrl_q;
   assign bus.stall_count = stall_q;

endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the register file.
- Drives the register file read addresses and captures the returned A/B operands.
- Resolves read-after-write hazards by bypassing from the MEM and WB stages, and inserts bubbles where bypassing is impossible.
- Presents a valid/ready-handshaked operand bundle to the execute stage.

Parameters:
CTRL_W, 16, width of opaque decoded-control bundle carried alongside operands
CNT_W, 16, width of saturating stall-cycle counter

Ports:
CLK  in  1  clock; all state on rising edge
Reset  in  1  asynchronous, active-low reset
in_valid  in  1  decode offers an instruction
in_ready  out  1  stage accepts offered instruction this cycle
in_rs  in  5  source register A
in_rt  in  5  source register B
in_dst  in  5  destination register
in_we  in  1  instruction writes in_dst
in_load  in  1  instruction is a load
in_ctrl  in  CTRL_W  decoded control bundle
R_a  out  5  register file read address A (= in_rs, combinational)
R_b  out  5  register file read address B (= in_rt, combinational)
RF_A  in  32  register file read data A
RF_B  in  32  register file read data B
mem_we, mem_load  in  1,1  MEM stage holds a register-writing instruction / that instruction is a load
mem_dst  in  5  MEM stage destination
mem_data  in  32  MEM stage ALU result (invalid when mem_load=1)
wb_we  in  1  write-back enable (same signal as the register file write enable)
wb_dst  in  5  write-back address
wb_data  in  32  write-back data
flush  in  1  kill the instruction being captured and the held output
out_valid  out  1  output bundle valid
out_ready  in  1  execute stage accepts bundle
out_A, out_B  out  32  resolved operands
out_dst  out  5  destination
out_we, out_load  out  1,1  writes register / is load
out_ctrl  out  CTRL_W  control bundle
stall_count  out  CNT_W  saturating count of hazard-bubble cycles

Behaviour:
- Reset (Reset=0, async): out_valid=0, out_A=out_B=0, out_dst=0, out_we=0, out_load=0, out_ctrl=0, stall_count=0. Takes effect immediately, including mid-stall; first capture possible on the first edge after release.
- Operand resolution, per source s with address r, combinational, in priority order:
  1. r==0 -> 0.
  2. mem_we & mem_dst==r & !mem_load -> mem_data.
  3. wb_we & wb_dst==r -> wb_data. This covers the same-cycle register file write.
  4. Otherwise RF_A / RF_B.
- hazard, for each used source with r!=0, is the OR of:
  - out_valid & out_we & out_dst==r (producer still in EX);
  - mem_we & mem_load & mem_dst==r (load data not yet available).
- advance = !out_valid | out_ready.
- in_ready = flush | (advance & !hazard).
- On each rising edge, first matching rule applies:
  1. flush -> out_valid<=0. The in_valid instruction is dropped, since in_ready=1 lets upstream retire it.
  2. !advance -> all outputs hold.
  3. in_valid & hazard -> bubble: out_valid<=0, other out_* don't care. stall_count += 1, saturating at all-ones.
  4. in_valid -> capture: out_valid<=1, resolved operands and the in_* fields are latched.
  5. Otherwise -> out_valid<=0.
- Latency: one cycle from accept to out_valid.
- Back-to-back accepts are allowed when no hazard is present.
- ALU-to-use costs 1 bubble. Load-to-use costs 2 bubbles (EX hazard, then MEM-load hazard).
- When out_valid=1 and out_ready=0, the output bundle stays stable until accepted.

Test Plan:
- Reset low mid-run with out_valid=1 -> all outputs 0 immediately. Release, in_valid with rs=3, RF_A=0x11 -> out_A=0x11 next cycle, out_valid=1.
- ADD $5 accepted, then a dependent instruction reading $5 -> one bubble, stall_count=1. Next cycle mem_dst=5, mem_data=0x2A -> out_A=0x2A.
- LW $6, then a use of $6 -> two bubbles, stall_count=2. Operand taken from wb_data=0xDEAD_BEEF while RF_B is stale 0.
- Source $0, with mem_dst=0 and mem_we=1, mem_data=0xFFFF -> out_A=0.
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and the output bundle is constant. out_ready=1 -> next instruction captured on the following edge.
- flush together with in_valid and a hazard present -> in_ready=1, out_valid=0 next cycle, stall_count unchanged.
